up_count: RTL and testbench
===========================

// Module: up_count
// PURPOSE
//  Programmable up-counting stopwatch, the count-up companion of the timer down-counter.
//  - Counts a 4-digit BCD value SS.hh (00.00 to 99.99 s) in 10 ms steps.
//  - Start/stop, clear and preset-load are taken from debounced single-cycle button pulses.
//  - The BCD output feeds the existing 7-segment display mux.
// PARAMETERS
//  CLK_HZ   100_000_000  input clock frequency
//  TICK_HZ  100          count rate; prescaler terminal = CLK_HZ/TICK_HZ - 1
// PORTS
//  clk         in   1   system clock, single clock domain
//  rst_n       in   1   asynchronous active-low reset
//  start_stop  in   1   1-cycle pulse: toggle run/stop
//  clear       in   1   1-cycle pulse: zero count, stop
//  set_time    in   1   1-cycle pulse: load preset, stop
//  di_hi       in   4   preset tens-of-seconds digit (switches)
//  di_lo       in   4   preset ones-of-seconds digit (switches)
//  bcd         out  16  {sec_tens, sec_ones, hund_tens, hund_ones}, 4 bits each
//  running     out  1   1 while in RUN
//  at_max      out  1   1 while in MAX (count saturated at 99.99)
// BEHAVIOUR
//  - Reset (async, rst_n=0) sets state STOP, bcd=16'h0000, running=0, at_max=0 and prescaler=0.
//  - All outputs are registered.
//  - Prescaler:
//    - Counts only in RUN; tick is asserted for 1 cycle when it reaches terminal, then it wraps to 0.
//    - It is forced to 0 on any state entry, so the first tick after start comes a full period later.
//  - Count: on tick, increment BCD with ripple carry, digit wraps 9->0 with carry.
//    - bcd updates on the clk edge after tick (1-cycle latency).
//  - Saturation: a tick when bcd==16'h9999 leaves bcd unchanged and moves to MAX.
//    - The count never wraps to 00.00.
//  - Preset: set_time loads bcd={clamp(di_hi),clamp(di_lo),4'h0,4'h0}.
//    - clamp(x) = (x>9) ? 9 : x.
//    - A loaded 99.00 counts normally to 99.99.
//  - FSM states STOP, RUN, MAX; priority clear > set_time > start_stop > tick.
//    - STOP: start_stop->RUN; clear->STOP (bcd=0); set_time->STOP (load).
//    - RUN: start_stop->STOP (bcd held); tick at 9999->MAX; clear/set_time->STOP.
//    - MAX: start_stop ignored; clear->STOP (bcd=0); set_time->STOP (load).
//  - Simultaneous pulses: only the highest-priority event acts; the others are dropped, not queued.
//    - A tick coinciding with clear, set_time or start_stop in RUN is discarded.
//  - running = (state==RUN); at_max = (state==MAX). Both are registered with state.
//  - Reset mid-count returns to the reset values immediately, with no clock needed.
// STRUCTURE
//  - Shared package/include stopwatch_pkg:
//    - state encoding (STOP/RUN/MAX)
//    - BCD digit width (4)
//    - MAX_BCD=16'h9999
//    - clamp function; this package is shared with the down-counter.
//  - Sub-module bcd_digit: mod-10 counter with en, load, ld_val, clr, carry_out.
//    - Instantiated 4x, carry chained hund_ones->sec_tens.
//  - Top holds the FSM, prescaler and preset clamp.
// TESTING (bench uses CLK_HZ=10, TICK_HZ=1 -> tick every 10 clk)
//  1. Reset, start_stop pulse, 250 clk -> bcd=16'h0025, running=1; start_stop -> bcd holds 0025.
//  2. Carry: set_time with di_hi=0, di_lo=9, run 1000 clk -> bcd=16'h1000 (09.99->10.00 ripple).
//  3. Saturation: set_time di_hi=9, di_lo=9, run 100 ticks -> bcd=16'h9999, at_max=1, running=0.
//     - A further start_stop pulse changes nothing; clear -> bcd=0, STOP.
//  4. Clamp: di_hi=4'hC, di_lo=4'hA, set_time -> bcd=16'h9900, state STOP.
//  5. Priority: clear+set_time+start_stop in the same cycle while RUN -> bcd=0, STOP.
//     - set_time+start_stop -> preset loaded, STOP.
//  6. Async reset: assert rst_n=0 between clk edges mid-RUN at 0042 -> bcd=0, running=0 before the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: definitions shared by the up-counting stopwatch and the
// timer down-counter.
//   sw_state_e : controller state encoding (STOP / RUN / MAX)
//   DIGIT_W    : width of one BCD digit
//   MAX_BCD    : saturation value 99.99
//   clamp()    : limits a switch-entered digit to 0..9
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int NUM_DIG = 4;
    localparam logic [NUM_DIG*DIGIT_W-1:0] MAX_BCD = 16'h9999;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_MAX  = 2'd2
    } sw_state_e;

    // Switches can present A..F. Those values saturate to 9 so the display
    // never shows a non-decimal digit.
    function automatic logic [DIGIT_W-1:0] clamp(input logic [DIGIT_W-1:0] x);
        return (x > 4'd9) ? 4'd9 : x;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one mod-10 BCD digit.
//   clk, rst_n : clock, async active-low reset
//   en         : advance by one (9 wraps to 0)
//   load/ld_val: load a preset digit
//   clr        : force to 0 (highest priority)
//   q          : registered digit value
//   carry_out  : asserted in the cycle the digit wraps 9->0; enables the next digit
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               clr,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);

    logic [DIGIT_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (load)
            q_d = ld_val;
        else if (en)
            q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    // Combinational carry so the whole chain ripples within a single cycle.
    assign carry_out = en & ~clr & ~load & (q_q == 4'd9);
    assign q         = q_q;

endmodule

// File: rtl/up_count.sv
// up_count: up-counting BCD stopwatch, SS.hh from 00.00 to 99.99 in
// 1/TICK_HZ steps, saturating at 99.99.
//   clk, rst_n       : clock, async active-low reset
//   start_stop       : pulse, toggle RUN/STOP (ignored in MAX)
//   clear            : pulse, zero the count and stop
//   set_time         : pulse, load {clamp(di_hi), clamp(di_lo), 0, 0} and stop
//   di_hi, di_lo     : preset seconds digits
//   bcd              : {sec_tens, sec_ones, hund_tens, hund_ones}
//   running, at_max  : registered state flags
module up_count
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_stop,
    input  logic                       clear,
    input  logic                       set_time,
    input  logic [DIGIT_W-1:0]         di_hi,
    input  logic [DIGIT_W-1:0]         di_lo,
    output logic [NUM_DIG*DIGIT_W-1:0] bcd,
    output logic                       running,
    output logic                       at_max
);

    localparam int TERM = CLK_HZ / TICK_HZ - 1;
    localparam int PW   = (TERM > 0) ? $clog2(TERM + 1) : 1;

    sw_state_e state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic running_q, at_max_q;

    logic [NUM_DIG-1:0][DIGIT_W-1:0] dig;
    logic [NUM_DIG-1:0][DIGIT_W-1:0] ld_val;
    logic [NUM_DIG-1:0]              dig_en;
    logic [NUM_DIG-1:0]              carry;

    logic tick;
    logic clr_ev, set_ev, ss_ev, tick_ev, inc;

    assign tick = (state_q == ST_RUN) && (presc_q == PW'(TERM));

    // One event per cycle, lower-priority pulses are dropped.
    assign clr_ev  = clear;
    assign set_ev  = ~clear & set_time;
    assign ss_ev   = ~clear & ~set_time & start_stop;
    assign tick_ev = ~clear & ~set_time & ~start_stop & tick;

    // At 99.99 the tick moves to MAX instead of incrementing.
    assign inc = tick_ev && (bcd != MAX_BCD);

    always_comb begin
        state_d = state_q;
        if (clr_ev || set_ev)
            state_d = ST_STOP;
        else if (ss_ev) begin
            if (state_q == ST_STOP)
                state_d = ST_RUN;
            else if (state_q == ST_RUN)
                state_d = ST_STOP;
        end else if (tick_ev && (bcd == MAX_BCD))
            state_d = ST_MAX;
    end

    // Prescaler runs only while staying in RUN; entering RUN starts it at 0
    // so the first tick is a full period after start.
    always_comb begin
        presc_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && !tick)
            presc_d = presc_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STOP;
            presc_q   <= '0;
            running_q <= 1'b0;
            at_max_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= (state_d == ST_RUN);
            at_max_q  <= (state_d == ST_MAX);
        end
    end

    assign ld_val[3] = clamp(di_hi);
    assign ld_val[2] = clamp(di_lo);
    assign ld_val[1] = '0;
    assign ld_val[0] = '0;

    // Carry chain: hund_ones -> hund_tens -> sec_ones -> sec_tens.
    assign dig_en[0] = inc;

    genvar g;
    generate
        for (g = 1; g < NUM_DIG; g++) begin : g_chain
            assign dig_en[g] = carry[g-1];
        end
        for (g = 0; g < NUM_DIG; g++) begin : g_dig
            bcd_digit u_dig (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (dig_en[g]),
                .load      (set_ev),
                .ld_val    (ld_val[g]),
                .clr       (clr_ev),
                .q         (dig[g]),
                .carry_out (carry[g])
            );
        end
    endgenerate

    assign bcd     = dig;
    assign running = running_q;
    assign at_max  = at_max_q;

endmodule

// File: tb/tb_up_count.sv
module tb_up_count;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_stop, clear, set_time;
    logic [3:0]  di_hi, di_lo;
    logic [15:0] bcd;
    logic        running, at_max;

    typedef struct {
        string       name;
        logic [15:0] bcd;
        logic        run;
        logic        mx;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    up_count #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .set_time   (set_time),
        .di_hi      (di_hi),
        .di_lo      (di_lo),
        .bcd        (bcd),
        .running    (running),
        .at_max     (at_max)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled on the falling edge, away from the
    // active edge, against whatever expectations are pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bcd !== e.bcd || running !== e.run || at_max !== e.mx) begin
                    miscompares++;
                    $display("FAIL %s: got bcd=%h running=%b at_max=%b, want bcd=%h running=%b at_max=%b",
                             e.name, bcd, running, at_max, e.bcd, e.run, e.mx);
                end
            end
        end
    end

    task automatic expect_out(input string name, input logic [15:0] b,
                              input logic r, input logic m);
        exp_t e;
        e.name = name; e.bcd = b; e.run = r; e.mx = m;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic st);
        start_stop = ss; clear = cl; set_time = st;
        cycles(1);
        start_stop = 1'b0; clear = 1'b0; set_time = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; set_time = 1'b0;
        di_hi = 4'h0; di_lo = 4'h0;
        cycles(2);
        expect_out("reset", 16'h0000, 1'b0, 1'b0);
        cycles(1);
        rst_n = 1'b1;
        cycles(2);

        // 1. basic run: tick every 10 clk, 25 ticks
        pulse(1'b1, 1'b0, 1'b0);
        cycles(9);
        expect_out("first_tick_not_early", 16'h0000, 1'b1, 1'b0);
        cycles(241);
        expect_out("run_250", 16'h0025, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("stop_hold", 16'h0025, 1'b0, 1'b0);
        cycles(30);
        expect_out("stop_hold_later", 16'h0025, 1'b0, 1'b0);

        // 2. ripple carry 09.99 -> 10.00
        di_hi = 4'h0; di_lo = 4'h9;
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("preset_0900", 16'h0900, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(990);
        expect_out("run_0999", 16'h0999, 1'b1, 1'b0);
        cycles(10);
        expect_out("carry_1000", 16'h1000, 1'b1, 1'b0);

        // 3. saturation (set_time while RUN also stops)
        di_hi = 4'h9; di_lo = 4'h9;
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("preset_9900_from_run", 16'h9900, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(990);
        expect_out("reach_9999", 16'h9999, 1'b1, 1'b0);
        cycles(10);
        expect_out("saturate_max", 16'h9999, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(20);
        expect_out("max_ignores_start", 16'h9999, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("max_clear", 16'h0000, 1'b0, 1'b0);

        // 4. clamp
        di_hi = 4'hC; di_lo = 4'hA;
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("clamp_9900", 16'h9900, 1'b0, 1'b0);

        // 5. priority
        pulse(1'b1, 1'b0, 1'b0);
        cycles(15);
        expect_out("run_9901", 16'h9901, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b1);
        expect_out("prio_clear", 16'h0000, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(5);
        di_hi = 4'h1; di_lo = 4'h2;
        pulse(1'b1, 1'b0, 1'b1);
        expect_out("prio_set_over_start", 16'h1200, 1'b0, 1'b0);
        cycles(20);
        expect_out("prio_set_stays_stop", 16'h1200, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(9);
        pulse(1'b1, 1'b0, 1'b0);   // lands on the tick cycle; tick dropped
        expect_out("tick_dropped_on_stop", 16'h1200, 1'b0, 1'b0);

        // 6. async reset mid-run
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(420);
        expect_out("run_0042", 16'h0042, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", 16'h0000, 1'b0, 1'b0);

        // drain pending checks with a bound
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d checks pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
